hgcal_input_packer: RTL

- Upstream feeder for the first LogicNets layer of the HGCAL autoencoder.
- Assembles a narrow valid/ready beat stream into one full-width activation frame (128 inputs x 2 bits = 256 bits).
- Presents the frame, held stable, on a valid/ready output whose data drives layer1's M0 bus directly.
- Double-buffered (assembly + output register), so upstream streams without bubbles while layer1's consumer is ready.

---
 rtl/hgcal_pkg.sv | 22 ++
 rtl/hgcal_frame_reg.sv | 49 ++++
 rtl/hgcal_input_packer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/hgcal_pkg.sv
// Shared widths, FSM state type and sizing helpers for the HGCAL autoencoder
// input path; imported by the packer and its output register.
package hgcal_pkg;

    localparam int HGCAL_IN_W  = 32;
    localparam int HGCAL_OUT_W = 256;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } pk_state_e;

    function automatic int calc_beats(input int out_w, input int in_w);
        return out_w / in_w;
    endfunction

    function automatic bit width_ok(input int out_w, input int in_w);
        return (in_w > 0) && (out_w >= in_w) && ((out_w % in_w) == 0);
    endfunction

endpackage

// File: rtl/hgcal_frame_reg.sv
// Output holding register with valid/ready semantics: data is frozen while
// valid is high and the consumer is stalled; a new load may replace a frame
// in the same cycle it is taken.
module hgcal_frame_reg #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         can_load_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load_ok;

    assign can_load_o = !valid_q || ready_i;
    assign load_ok    = load_i && can_load_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_ok) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/hgcal_input_packer.sv
// Packs IN_W-bit beats into one OUT_W-bit activation frame for layer1 M0.
// Optional frame statistics enabled by defining HGCAL_PACKER_STATS_EN.
//
//   state | meaning
//   FILL  | accumulating beats into the assembly buffer
//   HOLD  | assembly buffer full, waiting for the output register
//   DROP  | discarding beats after a long frame until s_last resyncs
module hgcal_input_packer
    import hgcal_pkg::*;
#(
    parameter int IN_W  = HGCAL_IN_W,
    parameter int OUT_W = HGCAL_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             err_frame
`ifdef HGCAL_PACKER_STATS_EN
    ,
    output logic [15:0]      frames_out,
    output logic [15:0]      frames_dropped
`endif
);

    localparam int BEATS = calc_beats(OUT_W, IN_W);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!width_ok(OUT_W, IN_W)) begin : g_bad_width
        $error("hgcal_input_packer: OUT_W must be a non-zero multiple of IN_W");
    end

    pk_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] asm_q, asm_d;
    logic             err_q, err_d;
    logic             xfer;
    logic             out_free;
    logic             accept;
    logic             at_last_slot;

    assign s_ready      = rst_n && (state_q != HOLD);
    assign accept       = s_valid && s_ready;
    assign at_last_slot = (cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        err_d   = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            asm_d[k*IN_W +: IN_W] = s_data;
                        end
                    end
                    if (at_last_slot) begin
                        cnt_d = '0;
                        if (!s_last) begin
                            err_d   = 1'b1;
                            state_d = DROP;
                        end else if (out_free) begin
                            xfer = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else if (s_last) begin
                        // Short frame: drop the partial and start over.
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    xfer    = 1'b1;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            DROP: begin
                if (accept && s_last) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
        end
    end

    // asm_d carries the final beat when the frame completes this cycle,
    // which is what gives the one-cycle last-beat-to-m_valid latency.
    hgcal_frame_reg #(
        .W (OUT_W)
    ) u_frame_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (xfer),
        .data_i     (asm_d),
        .ready_i    (m_ready),
        .can_load_o (out_free),
        .valid_o    (m_valid),
        .data_o     (m_data)
    );

    assign err_frame = err_q;

`ifdef HGCAL_PACKER_STATS_EN
    logic [15:0] frames_out_q, frames_out_d;
    logic [15:0] frames_dropped_q, frames_dropped_d;

    always_comb begin
        frames_out_d     = frames_out_q;
        frames_dropped_d = frames_dropped_q;
        if (m_valid && m_ready && (frames_out_q != 16'hFFFF)) begin
            frames_out_d = frames_out_q + 16'd1;
        end
        if (err_q && (frames_dropped_q != 16'hFFFF)) begin
            frames_dropped_d = frames_dropped_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames_out_q     <= '0;
            frames_dropped_q <= '0;
        end else begin
            frames_out_q     <= frames_out_d;
            frames_dropped_q <= frames_dropped_d;
        end
    end

    assign frames_out     = frames_out_q;
    assign frames_dropped = frames_dropped_q;
`endif

endmodule
